lsu: RTL and testbench
======================

# lsu

Load/store unit for the memory stage, directly downstream of the ALU. It takes the effective address the ALU computes with ADD for lw/sw/lb/lh/lbu/lhu/sb/sh, drives a single-outstanding req/ack data-memory port, and performs byte-lane steering, store-data replication and load sign/zero extension. It returns a one-cycle `done` pulse with the extended load data and an error flag to the control unit.

## Interface
- `TIMEOUT`, 255: watchdog limit in cycles of `mem_req` without `mem_ack`; used only with `LSU_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe; sampled only in IDLE.
- `ls_op` in 4: bit3 store, bit2 unsigned load, bits[1:0] size (00 byte, 01 half, 10 word, 11 illegal).
- `addr` in 32: effective address from the ALU `result`.
- `wdata` in 32: store data (rt).
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load data, valid with `done`, held until the next load completes.
- `err` out 1: valid with `done`; misaligned/illegal access or timeout.
- `mem_req` out 1, `mem_we` out 1, `mem_be` out 4, `mem_addr` out 32, `mem_wdata` out 32: memory request.
- `mem_ack` in 1, `mem_rdata` in 32: memory response; `mem_rdata` is valid in the `mem_ack` cycle.

## Operation
- FSM states:
  - IDLE: `start` → REQ, or → RESP when the access is bad.
  - REQ: `mem_ack` → RESP; timeout → RESP.
  - RESP: → IDLE unconditionally.
- On an accepted `start`, register op, `addr` and `wdata`. `start` is ignored while busy.
- Bad access: size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - No memory request is issued.
  - `err`=1 in RESP; `rdata` unchanged.
- `mem_addr` = {addr[31:2], 2'b00}. Byte lanes are little-endian.
- Stores: `mem_we`=1.
  - SB: byte replicated ×4, `mem_be` = 1<<addr[1:0].
  - SH: half replicated ×2, `mem_be` = 0011 or 1100 by addr[1].
  - SW: `mem_be` = 1111.
  - bit2 is ignored.
- Loads: `mem_we`=0, `mem_be`=1111.
  - Select the lane from `mem_rdata` using addr[1:0].
  - Sign-extend when bit2=0, zero-extend when bit2=1. Capture into `rdata` on ack.
- Stores leave `rdata` unchanged.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_req`, `mem_we` = 0; `mem_be`=0; `mem_addr`, `mem_wdata`, `rdata` = 0.
- All outputs are registered.
- `mem_req` rises the cycle after `start`. `mem_addr`/`mem_be`/`mem_we`/`mem_wdata` stay stable while `mem_req`=1. `mem_req` falls the cycle after `mem_ack` is sampled.
- Latency:
  - Ack in the first REQ cycle: `done` 3 cycles after `start`.
  - Each wait cycle adds 1.
  - Bad access: `done` 2 cycles after `start`.
- `mem_ack` outside REQ is ignored. Back-to-back: the earliest next `start` is the cycle after `done`.
- Reset mid-operation: `mem_req` and `busy` drop asynchronously; no `done` is generated.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter in REQ, cleared on entry.
  - At `TIMEOUT` cycles with no ack: drop `mem_req`, go to RESP with `err`=1, `rdata` unchanged.
  - A late `mem_ack` is ignored.
- Not defined: no counter; REQ waits indefinitely; `err` comes only from bad accesses.

## Structure
- Shared package `lsu_pkg`: `ls_op` field positions, size codes (SZ_B, SZ_H, SZ_W), FSM state encoding.
- Sub-module `lsu_align`: purely combinational. It produces `mem_be`/`mem_wdata` from op/addr/wdata, and the extended load word from `mem_rdata`/addr/op. The FSM stays in `lsu`.

## Test plan
- LW: `addr`=0x100; ack after 2 wait cycles with `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_be`=1111; `done` 5 cycles after `start`, `rdata`=0xDEADBEEF, `err`=0.
- LB / LBU: `addr`=0x103, `mem_rdata`=0x80FF1234 → LB gives `rdata`=0xFFFFFF80; LBU gives 0x00000080.
- SH: `addr`=0x202, `wdata`=0x0000ABCD → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x200.
- Misaligned LW at 0x101 → no `mem_req`; `done`+`err` 2 cycles after `start`; `rdata` keeps its prior value.
- `start` pulsed while busy, plus reset asserted mid-REQ → the second `start` is ignored; on reset `mem_req`=0 immediately and no `done` is generated.
- `LSU_TIMEOUT_EN`, `TIMEOUT`=4, `mem_ack` never asserted → `mem_req` high for exactly 4 cycles, then `done`=1 with `err`=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - ls_op field positions (store flag, unsigned-load flag, size field)
//   - access size codes SZ_B / SZ_H / SZ_W (SZ_X is the illegal code)
//   - FSM state encoding
//   - is_bad(): misaligned or illegal access detection
package lsu_pkg;

   localparam int OP_STORE = 3;  // ls_op bit: 1 = store
   localparam int OP_UNS   = 2;  // ls_op bit: 1 = zero-extend load

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // An access is bad when its size code is illegal or it is not naturally aligned.
   function automatic logic is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return addr_lo[0];
         SZ_W:    return addr_lo != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle of the load/store unit.
//   Control side : start, ls_op[3:0], addr[31:0], wdata[31:0] -> busy, done, rdata[31:0], err
//   Memory side  : mem_req, mem_we, mem_be[3:0], mem_addr[31:0], mem_wdata[31:0]
//                  <- mem_ack, mem_rdata[31:0]
// Modports: slave = the lsu itself, master = the environment driving it.
interface lsu_if;
   logic        start;
   logic [3:0]  ls_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  start, ls_op, addr, wdata, mem_ack, mem_rdata,
      output busy, done, rdata, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output start, ls_op, addr, wdata, mem_ack, mem_rdata,
      input  busy, done, rdata, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic of the load/store unit.
//   Store side : st, size, addr_lo, wdata        -> be, wdata_rep
//                (loads get be = 1111; store data is replicated to every lane)
//   Load side  : ld_size, ld_uns, ld_addr_lo, mem_rdata -> ld_data
//                (little-endian lane select, then sign or zero extension)
module lsu_align
   import lsu_pkg::*;
(
   input  logic        st,
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   input  logic [1:0]  ld_size,
   input  logic        ld_uns,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        ext;

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      if (st) begin
         case (size)
            SZ_B: begin
               be        = 4'b0001 << addr_lo;
               wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
               be        = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (ld_addr_lo)
         2'd0:    lane_b = mem_rdata[7:0];
         2'd1:    lane_b = mem_rdata[15:8];
         2'd2:    lane_b = mem_rdata[23:16];
         default: lane_b = mem_rdata[31:24];
      endcase
      lane_h = ld_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ext    = 1'b0;
      case (ld_size)
         SZ_B: begin
            ext     = ~ld_uns & lane_b[7];
            ld_data = {{24{ext}}, lane_b};
         end
         SZ_H: begin
            ext     = ~ld_uns & lane_h[15];
            ld_data = {{16{ext}}, lane_h};
         end
         default: ld_data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit for the memory stage.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : lsu_if.slave -- start/ls_op/addr/wdata in, busy/done/rdata/err out,
//                single-outstanding req/ack data-memory port
// Parameter TIMEOUT: cycles of mem_req without mem_ack before the access is abandoned.
// Optional feature macro LSU_TIMEOUT_EN: enables the REQ watchdog; without it REQ waits
// indefinitely and err is raised only by bad accesses.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input logic  clk,
   input logic  rst_n,
   lsu_if.slave bus
);

   state_e      state;
   logic [1:0]  ld_size_q;
   logic        ld_uns_q;
   logic [1:0]  addr_lo_q;
   logic        err_q;      // error result waiting in RESP to be reported with done
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [31:0] ld_data;
   logic        bad;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wd_cnt;
`endif

   // Store lanes come from the incoming request; load extension uses the captured op.
   lsu_align u_align (
      .st         (bus.ls_op[OP_STORE]),
      .size       (bus.ls_op[1:0]),
      .addr_lo    (bus.addr[1:0]),
      .wdata      (bus.wdata),
      .be         (be_nxt),
      .wdata_rep  (wdata_nxt),
      .ld_size    (ld_size_q),
      .ld_uns     (ld_uns_q),
      .ld_addr_lo (addr_lo_q),
      .mem_rdata  (bus.mem_rdata),
      .ld_data    (ld_data)
   );

   assign bad = is_bad(bus.ls_op[1:0], bus.addr[1:0]);

   // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         ld_size_q     <= SZ_B;
         ld_uns_q      <= 1'b0;
         addr_lo_q     <= 2'b00;
         err_q         <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.rdata     <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
`ifdef LSU_TIMEOUT_EN
         wd_cnt        <= '0;
`endif
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  ld_size_q <= bus.ls_op[1:0];
                  ld_uns_q  <= bus.ls_op[OP_UNS];
                  addr_lo_q <= bus.addr[1:0];
                  bus.busy  <= 1'b1;
                  if (bad) begin
                     // Skip the memory entirely; the error is reported from RESP.
                     err_q <= 1'b1;
                     state <= ST_RESP;
                  end else begin
                     err_q         <= 1'b0;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.ls_op[OP_STORE];
                     bus.mem_be    <= be_nxt;
                     bus.mem_addr  <= {bus.addr[31:2], 2'b00};
                     bus.mem_wdata <= wdata_nxt;
                     state         <= ST_REQ;
`ifdef LSU_TIMEOUT_EN
                     wd_cnt        <= '0;
`endif
                  end
               end
            end
            ST_REQ: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  if (!bus.mem_we) bus.rdata <= ld_data;
                  state <= ST_RESP;
               end
`ifdef LSU_TIMEOUT_EN
               else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                  bus.mem_req <= 1'b0;
                  err_q       <= 1'b1;
                  state       <= ST_RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`else
               // Without the watchdog REQ holds until the memory acknowledges.
`endif
            end
            ST_RESP: begin
               bus.done <= 1'b1;
               bus.err  <= err_q;
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   lsu_if bus ();

   lsu #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;     // memory read data returned with ack
      int          waits;   // wait cycles before ack, -1 = never ack
      logic        bad;
      logic [3:0]  be;
      logic [31:0] mwd;     // expected mem_wdata (stores only)
      logic [31:0] rdata;   // expected rdata at done
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: each done pops the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rdata at done", bus.rdata, e.rdata);
            check("err at done", {31'd0, bus.err}, {31'd0, e.err});
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int k, lat_exp, req_exp, n_req;
      bit got;
      lat_exp = v.bad ? 2 : (v.waits < 0 ? TO + 2 : v.waits + 3);
      req_exp = v.bad ? 0 : (v.waits < 0 ? TO : v.waits + 1);
      n_req   = 0;
      got     = 0;
      @(posedge clk); #1;
      k = cyc;
      bus.start = 1'b1;
      bus.ls_op = v.op;
      bus.addr  = v.addr;
      bus.wdata = v.wdata;
      sb_q.push_back('{rdata: v.rdata, err: v.bad || (v.waits < 0)});
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.mem_ack = 1'b0;
         if (bus.mem_req === 1'b1) begin
            n_req++;
            check({v.name, " mem_addr"}, bus.mem_addr, v.addr & 32'hFFFF_FFFC);
            check({v.name, " mem_be"}, {28'd0, bus.mem_be}, {28'd0, v.be});
            check({v.name, " mem_we"}, {31'd0, bus.mem_we}, {31'd0, v.op[3]});
            if (v.op[3]) check({v.name, " mem_wdata"}, bus.mem_wdata, v.mwd);
         end
         if (!v.bad && i == v.waits) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.mrd;
         end
         if (bus.done === 1'b1) begin
            got = 1;
            check({v.name, " latency"}, cyc - k, lat_exp);
         end
      end
      bus.mem_ack = 1'b0;
      if (!got) check({v.name, " done within budget"}, 32'd0, 32'd1);
      check({v.name, " mem_req cycles"}, n_req, req_exp);
   endtask

   vec_t vecs[13];

   initial begin
      bus.start = 1'b0;
      bus.ls_op = '0;
      bus.addr = '0;
      bus.wdata = '0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;

      //             name     op       addr          wdata         mrd           w  bad be       mwd           rdata
      vecs[0]  = '{"LW",   4'b0010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
      vecs[1]  = '{"LB",   4'b0000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 4'b1111, 32'h0,        32'hFFFF_FF80};
      vecs[2]  = '{"LBU",  4'b0100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 0, 4'b1111, 32'h0,        32'h0000_0080};
      vecs[3]  = '{"SH",   4'b1001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080};
      vecs[4]  = '{"LWmis",4'b0010, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0000_0080};
      vecs[5]  = '{"LH",   4'b0001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 0, 4'b1111, 32'h0,        32'hFFFF_80FF};
      vecs[6]  = '{"LHU",  4'b0101, 32'h0000_0100, 32'h0,        32'h80FF_1234, 3, 0, 4'b1111, 32'h0,        32'h0000_1234};
      vecs[7]  = '{"SB",   4'b1000, 32'h0000_03F1, 32'h1234_5678, 32'h0,        1, 0, 4'b0010, 32'h7878_7878, 32'h0000_1234};
      vecs[8]  = '{"SW",   4'b1010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_1234};
      vecs[9]  = '{"SZ11", 4'b0011, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0000_1234};
      vecs[10] = '{"LHmis",4'b0001, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0000_1234};
      vecs[11] = '{"LB1",  4'b0000, 32'h0000_0101, 32'h0,        32'h80FF_1234, 0, 0, 4'b1111, 32'h0,        32'h0000_0012};
      vecs[12] = '{"SBu",  4'b1100, 32'h0000_0003, 32'h0000_00AB, 32'h0,        0, 0, 4'b1000, 32'hABAB_ABAB, 32'h0000_0012};

      // Reset values
      #12;
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset err", {31'd0, bus.err}, 32'd0);
      check("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("reset mem_be", {28'd0, bus.mem_be}, 32'd0);
      check("reset mem_addr", bus.mem_addr, 32'd0);
      check("reset mem_wdata", bus.mem_wdata, 32'd0);
      check("reset rdata", bus.rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // mem_ack while idle is ignored: no done, rdata unchanged
      @(posedge clk); #1;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h5555_AAAA;
      repeat (3) @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle ack busy", {31'd0, bus.busy}, 32'd0);
      check("idle ack rdata", bus.rdata, 32'h0000_0012);

      // Start while busy is ignored, then reset in the middle of REQ
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.ls_op = 4'b0010;
      bus.addr  = 32'h0000_0500;
      @(posedge clk); #1;
      check("busy in REQ", {31'd0, bus.busy}, 32'd1);
      check("mem_req in REQ", {31'd0, bus.mem_req}, 32'd1);
      bus.addr  = 32'h0000_0600;
      bus.ls_op = 4'b1010;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("2nd start ignored addr", bus.mem_addr, 32'h0000_0500);
      check("2nd start ignored we", {31'd0, bus.mem_we}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("async reset busy", {31'd0, bus.busy}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("no done after reset", {31'd0, bus.done}, 32'd0);
      check("rdata cleared by reset", bus.rdata, 32'd0);
      check("queue empty after reset", sb_q.size(), 32'd0);

      // Recovery after reset
      run_vec('{"LWpost", 4'b0010, 32'h0000_0010, 32'h0, 32'h0123_4567, 0, 0, 4'b1111, 32'h0, 32'h0123_4567});

`ifdef LSU_TIMEOUT_EN
      // Watchdog: no ack ever; a late ack afterwards is ignored
      run_vec('{"LWto", 4'b0010, 32'h0000_0700, 32'h0, 32'h0, -1, 0, 4'b1111, 32'h0, 32'h0123_4567});
      @(posedge clk); #1;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("late ack rdata", bus.rdata, 32'h0123_4567);
`endif

      repeat (3) @(posedge clk);
      check("scoreboard drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
